// File: rtl/fetch2_pkg.sv
// Shared types for the second fetch stage: the fetch packet layout handed to decode.
package fetch2_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr_0;
    logic [INSTR_W-1:0] instr_1;
    logic               slot1_valid;
    logic               pred_taken;
    logic               pred_slot;
    logic [XLEN-1:0]    pred_tgt;
  } fetch_pkt_t;

  localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

  // Bit ranges of each field inside the packed entry (MSB first).
  localparam int PKT_PC_MSB   = FETCH_PKT_W - 1;
  localparam int PKT_I0_MSB   = PKT_PC_MSB - XLEN;
  localparam int PKT_I1_MSB   = PKT_I0_MSB - INSTR_W;
  localparam int PKT_S1V_BIT  = PKT_I1_MSB - INSTR_W;
  localparam int PKT_TKN_BIT  = PKT_S1V_BIT - 1;
  localparam int PKT_SLOT_BIT = PKT_TKN_BIT - 1;
  localparam int PKT_TGT_MSB  = PKT_SLOT_BIT - 1;

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush, occupancy count and a sticky overflow flag.
module fetch_queue #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_enq,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_deq,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [PTR_W:0]   o_count,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             r_ovf;
  logic             w_do_enq;
  logic             w_do_deq;

  assign o_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                    (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_count  = r_wptr - r_rptr;
  assign w_do_deq = i_deq & ~o_empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_do_enq = i_enq & (~o_full | w_do_deq);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else if (i_flush) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_do_enq) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_do_deq) r_rptr <= r_rptr + (PTR_W+1)'(1);
      if (i_enq && o_full && !w_do_deq) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_enq && !i_flush) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
  end

  assign o_rdata    = r_mem[r_rptr[PTR_W-1:0]];
  assign o_overflow = r_ovf;

endmodule

// File: rtl/fetch2.sv
// Second fetch stage: aligns fetch1 PC/predictions with imem data and queues packets for decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH2_BYPASS_EN.
import fetch2_pkg::*;

module fetch2 #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] pc_i,
  input  logic        pred_0_i,
  input  logic        pred_1_i,
  input  logic [31:0] pred_tgt_0_i,
  input  logic [31:0] pred_tgt_1_i,
  input  logic [31:0] imem_instr_0_i,
  input  logic [31:0] imem_instr_1_i,
  input  logic        flush_i,
  input  logic        deq_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_0_o,
  output logic [31:0] instr_1_o,
  output logic        slot1_valid_o,
  output logic        pred_taken_o,
  output logic        pred_slot_o,
  output logic [31:0] pred_tgt_o,
  output logic        stall_o,
  output logic        overflow_o
);

  logic        r_a_vld_p0;
  logic [31:0] r_a_pc_p0;
  logic        r_a_pred0_p0;
  logic        r_a_pred1_p0;
  logic [31:0] r_a_tgt0_p0;
  logic [31:0] r_a_tgt1_p0;

  fetch_pkt_t     w_a_pkt;
  fetch_pkt_t     w_head;
  fetch_pkt_t     w_out;
  logic           w_out_vld;
  logic           w_enq;
  logic           w_empty;
  logic           w_full;
  logic [PTR_W:0] w_count;
  logic [PTR_W+1:0] w_fill;

  // Stage A: capture fetch1 state; imem data for this PC arrives next cycle.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i || flush_i) r_a_vld_p0 <= 1'b0;
    else                       r_a_vld_p0 <= fetch_valid_i;
  end

  always_ff @(posedge clock_i) begin
    r_a_pc_p0    <= pc_i;
    r_a_pred0_p0 <= pred_0_i;
    r_a_pred1_p0 <= pred_1_i;
    r_a_tgt0_p0  <= pred_tgt_0_i;
    r_a_tgt1_p0  <= pred_tgt_1_i;
  end

  // Packet formation: a taken slot 0 squashes slot 1.
  always_comb begin
    w_a_pkt             = '0;
    w_a_pkt.pc          = r_a_pc_p0;
    w_a_pkt.instr_0     = imem_instr_0_i;
    w_a_pkt.instr_1     = imem_instr_1_i;
    w_a_pkt.slot1_valid = 1'b1;
    if (r_a_pred0_p0) begin
      w_a_pkt.slot1_valid = 1'b0;
      w_a_pkt.pred_taken  = 1'b1;
      w_a_pkt.pred_tgt    = r_a_tgt0_p0;
    end else if (r_a_pred1_p0) begin
      w_a_pkt.pred_taken  = 1'b1;
      w_a_pkt.pred_slot   = 1'b1;
      w_a_pkt.pred_tgt    = r_a_tgt1_p0;
    end
  end

`ifdef FETCH2_BYPASS_EN
  assign w_enq = r_a_vld_p0 & ~flush_i & ~(w_empty & deq_i);
`else
  assign w_enq = r_a_vld_p0 & ~flush_i;
`endif

  // Queue stage: packets wait here until decode takes them.
  fetch_queue #(
    .WIDTH (FETCH_PKT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk      (clock_i),
    .i_rst_n    (reset_n_i),
    .i_flush    (flush_i),
    .i_enq      (w_enq),
    .i_wdata    (w_a_pkt),
    .i_deq      (deq_i),
    .o_rdata    (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_count    (w_count),
    .o_overflow (overflow_o)
  );

  always_comb begin
    w_out     = '0;
    w_out_vld = 1'b0;
    if (!w_empty) begin
      w_out_vld = 1'b1;
      w_out     = w_head;
    end
`ifdef FETCH2_BYPASS_EN
    else if (r_a_vld_p0) begin
      w_out_vld = 1'b1;
      w_out     = w_a_pkt;
    end
`endif
  end

  // Counting the packet in A reserves room for the fetch fetch1 has already issued.
  assign w_fill  = {1'b0, w_count} + (PTR_W+2)'(r_a_vld_p0);
  assign stall_o = (w_fill >= (PTR_W+2)'(DEPTH-1));

  assign valid_o       = w_out_vld;
  assign pc_o          = w_out.pc;
  assign instr_0_o     = w_out.instr_0;
  assign instr_1_o     = w_out.instr_1;
  assign slot1_valid_o = w_out.slot1_valid;
  assign pred_taken_o  = w_out.pred_taken;
  assign pred_slot_o   = w_out.pred_slot;
  assign pred_tgt_o    = w_out.pred_tgt;

endmodule
